// File: rtl/sigm_seq.sv
// ---------------------------------------------------------------------------
// sigm_seq -- sequencer for the piecewise-quadratic sigmoid.
//
// Accepts one Q8.24 operand per request, selects the polynomial segment for
// the external combinational coefficient selector (sigm_coef) and evaluates
//   p = c0 + |x| * (c1 + |x| * c2)
// in Horner form on a single shared multiplier. Negative inputs use the
// symmetry y = 1.0 - p.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   i_start   in   request strobe, only honoured in IDLE
//   i_x       in   operand (Q8.24), sampled on the accepting edge
//   o_sel     out  3-bit segment select to sigm_coef (registered)
//   i_coef0/1/2 in coefficients returned by sigm_coef for o_sel
//   o_busy    out  high while a request is in flight
//   o_valid   out  one-cycle result strobe
//   o_y       out  result (Q8.24), held until the next result
// ---------------------------------------------------------------------------
module sigm_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  output logic [2:0]       o_sel,
  input  logic [WIDTH-1:0] i_coef0,
  input  logic [WIDTH-1:0] i_coef1,
  input  logic [WIDTH-1:0] i_coef2,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_y
);

  localparam int IW = WIDTH - FRAC;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(IW-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_H1   = 2'd1,
    S_H2   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_acc;
  logic             r_s;
  logic [2:0]       r_sel;
  logic             r_valid;
  logic [WIDTH-1:0] r_y;

  logic [WIDTH-1:0]          w_abs;
  logic [IW-1:0]             w_k;
  logic [2:0]                w_seg;
  logic [WIDTH-1:0]          w_mul_b;
  logic signed [2*WIDTH-1:0] w_pa;
  logic signed [2*WIDTH-1:0] w_pb;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]          w_mul;
  logic [WIDTH-1:0]          w_sum;

  // Magnitude of the incoming operand; the most negative value has no
  // positive counterpart and saturates to the largest positive one.
  always_comb begin
    w_abs = i_x;
    if (i_x == MIN_NEG) begin
      w_abs = MAX_POS;
    end else if (i_x[WIDTH-1]) begin
      w_abs = -i_x;
    end
  end

  // Segment from the integer part of |x|: 0..3 map directly, 4 and 5 share
  // segment 4, everything from 6 upwards is the flat saturation segment.
  assign w_k = w_abs[WIDTH-1:FRAC];

  always_comb begin
    w_seg = 3'd5;
    if (w_k < IW'(4)) begin
      w_seg = w_k[2:0];
    end else if (w_k < IW'(6)) begin
      w_seg = 3'd4;
    end
  end

  // Shared multiplier: H1 multiplies by c2, H2 by the running accumulator.
  // Both operands are sign-extended so the full-width product is exact.
  assign w_mul_b = (r_state == S_H1) ? i_coef2 : r_acc;
  assign w_pa    = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_pb    = {{WIDTH{w_mul_b[WIDTH-1]}}, w_mul_b};
  assign w_prod  = w_pa * w_pb;
  // Truncate (no rounding) back to Q8.24.
  assign w_mul   = WIDTH'(w_prod >>> FRAC);
  // Shared adder: c1 is added in H1, c0 in H2. Wraps on overflow.
  assign w_sum   = ((r_state == S_H1) ? i_coef1 : i_coef0) + w_mul;

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_H1;
      S_H1:    w_state_next = S_H2;
      S_H2:    w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_acc   <= '0;
      r_s     <= 1'b0;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
      r_y     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s   <= i_x[WIDTH-1];
            r_a   <= w_abs;
            r_sel <= w_seg;
          end
        end
        S_H1: begin
          r_acc <= w_sum;
        end
        S_H2: begin
          r_acc <= w_sum;
        end
        S_FIN: begin
          r_y     <= r_s ? (ONE - r_acc) : r_acc;
          r_valid <= 1'b1;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_busy  = (r_state != S_IDLE);
  assign o_valid = r_valid;
  assign o_y     = r_y;

endmodule

// File: tb/tb_sigm_seq.sv
// ---------------------------------------------------------------------------
// tb_sigm_seq -- self-checking bench for sigm_seq.
// Stands in for sigm_coef with a small coefficient table and checks results
// against an arithmetic reference of the sigmoid polynomial.
// ---------------------------------------------------------------------------
module tb_sigm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_x;
  logic [2:0]  o_sel;
  logic [31:0] coef0, coef1, coef2;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_y;

  int tests = 0;
  int fails = 0;

  logic [31:0] tbl_c0 [8];
  logic [31:0] tbl_c1 [8];
  logic [31:0] tbl_c2 [8];

  always #5 clk = ~clk;

  // Combinational coefficient selector model.
  assign coef0 = tbl_c0[o_sel];
  assign coef1 = tbl_c1[o_sel];
  assign coef2 = tbl_c2[o_sel];

  sigm_seq #(.WIDTH(32), .FRAC(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_x     (i_x),
    .o_sel   (o_sel),
    .i_coef0 (coef0),
    .i_coef1 (coef1),
    .i_coef2 (coef2),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_y     (o_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_abs(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    return x[31] ? -x : x;
  endfunction

  function automatic logic [2:0] ref_sel(input logic [31:0] x);
    int k;
    k = int'(ref_abs(x) >> 24);
    if (k < 4) return 3'(k);
    if (k < 6) return 3'd4;
    return 3'd5;
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] x);
    logic [31:0] a, t, acc;
    logic [2:0]  s;
    longint      p;
    a   = ref_abs(x);
    s   = ref_sel(x);
    p   = longint'($signed(a)) * longint'($signed(tbl_c2[s]));
    t   = tbl_c1[s] + 32'(p >>> 24);
    p   = longint'($signed(a)) * longint'($signed(t));
    acc = tbl_c0[s] + 32'(p >>> 24);
    return x[31] ? (32'h0100_0000 - acc) : acc;
  endfunction

  // One request; entered and left at a falling edge with the DUT idle.
  // Leaves the bench in the o_valid cycle so calls can chain back-to-back.
  task automatic run_one(input logic [31:0] x, output logic [31:0] y_obs);
    logic [31:0] ey;
    logic [2:0]  es;
    ey = ref_y(x);
    es = ref_sel(x);
    i_start = 1'b1;
    i_x     = x;
    @(negedge clk);
    i_start = 1'b0;
    i_x     = $urandom;
    check($sformatf("sel x=%h", x), 32'(o_sel), 32'(es));
    check($sformatf("busy1 x=%h", x), 32'(o_busy), 32'd1);
    check($sformatf("novalid1 x=%h", x), 32'(o_valid), 32'd0);
    @(negedge clk);
    i_x = $urandom;
    check($sformatf("busy2 x=%h", x), 32'(o_busy), 32'd1);
    @(negedge clk);
    check($sformatf("busy3 x=%h", x), 32'(o_busy), 32'd1);
    check($sformatf("novalid3 x=%h", x), 32'(o_valid), 32'd0);
    @(negedge clk);
    check($sformatf("idle x=%h", x), 32'(o_busy), 32'd0);
    check($sformatf("valid x=%h", x), 32'(o_valid), 32'd1);
    check($sformatf("y x=%h", x), o_y, ey);
    y_obs = o_y;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y;
    logic [31:0] x;
    logic [31:0] xs [17];
    logic        exp_v;

    tbl_c0[0] = 32'h009F_3B64; tbl_c1[0] = 32'h0040_0000; tbl_c2[0] = 32'hFFF0_0000;
    tbl_c0[1] = 32'h0080_0000; tbl_c1[1] = 32'h0060_0000; tbl_c2[1] = 32'h000B_4000;
    tbl_c0[2] = 32'h0090_0000; tbl_c1[2] = 32'h0038_0000; tbl_c2[2] = 32'hFFF8_0000;
    tbl_c0[3] = 32'h00A8_0000; tbl_c1[3] = 32'h0020_0000; tbl_c2[3] = 32'hFFFC_0000;
    tbl_c0[4] = 32'h00C8_0000; tbl_c1[4] = 32'h000C_0000; tbl_c2[4] = 32'hFFFF_0000;
    tbl_c0[5] = 32'h0100_0000; tbl_c1[5] = 32'h0000_0000; tbl_c2[5] = 32'h0000_0000;
    tbl_c0[6] = '0; tbl_c1[6] = '0; tbl_c2[6] = '0;
    tbl_c0[7] = '0; tbl_c1[7] = '0; tbl_c2[7] = '0;

    rst     = 1'b1;
    i_start = 1'b0;
    i_x     = '0;
    repeat (2) @(negedge clk);
    check("rst sel",   32'(o_sel),   32'd0);
    check("rst busy",  32'(o_busy),  32'd0);
    check("rst valid", 32'(o_valid), 32'd0);
    check("rst y",     o_y,          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero input: result is c0 of segment 0.
    run_one(32'h0000_0000, y);
    check("lit y(0)", y, 32'h009F_3B64);
    @(negedge clk);

    // +1.0 then -1.0 back-to-back (second accepted in the first valid cycle).
    run_one(32'h0100_0000, y);
    check("lit y(+1)", y, 32'h00EB_4000);
    run_one(32'hFF00_0000, y);
    check("lit y(-1)", y, 32'h0014_C000);
    check("lit sel(-1)", 32'(o_sel), 32'd1);

    // Saturation region.
    run_one(32'h0800_0000, y);
    check("lit y(8)", y, 32'h0100_0000);
    check("lit sel(8)", 32'(o_sel), 32'd5);
    run_one(32'hF800_0000, y);
    check("lit y(-8)", y, 32'h0000_0000);
    run_one(32'h8000_0000, y);
    check("lit y(min)", y, 32'h0000_0000);
    check("lit sel(min)", 32'(o_sel), 32'd5);

    // Segment boundaries.
    run_one(32'h0400_0000, y);
    check("lit sel(4.0)", 32'(o_sel), 32'd4);
    run_one(32'h05FF_FFFF, y);
    check("lit sel(5.99)", 32'(o_sel), 32'd4);
    run_one(32'h0600_0000, y);
    check("lit sel(6.0)", 32'(o_sel), 32'd5);
    run_one(32'h00FF_FFFF, y);
    check("lit sel(0.99)", 32'(o_sel), 32'd0);

    // Random operands: full range, then the interesting |x| < 8 region.
    for (int i = 0; i < 16; i++) begin
      run_one($urandom, y);
    end
    for (int i = 0; i < 24; i++) begin
      x = 32'($urandom_range(0, 32'h07FF_FFFF));
      if ($urandom_range(0, 1) == 1) x = -x;
      run_one(x, y);
    end
    @(negedge clk);

    // Busy rejection: i_start held high, x changing every cycle. Only the
    // operands present at accepting edges 0, 4, 8 produce results.
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) begin
        exp_v = (j >= 4) && (j % 4 == 0) && (j <= 12);
        check($sformatf("hold valid j=%0d", j), 32'(o_valid), 32'(exp_v));
        if (exp_v) check($sformatf("hold y j=%0d", j), o_y, ref_y(xs[j-4]));
      end
      xs[j]   = $urandom;
      i_x     = xs[j];
      i_start = (j < 12);
      @(negedge clk);
    end
    i_start = 1'b0;

    // Reset in the middle of an operation.
    run_one(32'h0100_0000, y);
    @(negedge clk);
    i_start = 1'b1;
    i_x     = 32'h0400_0000;
    @(negedge clk);
    i_start = 1'b0;
    check("abort sel", 32'(o_sel), 32'd4);
    @(negedge clk);
    // Now in H2.
    #2 rst = 1'b1;
    #1;
    check("async busy",  32'(o_busy),  32'd0);
    check("async valid", 32'(o_valid), 32'd0);
    check("async y",     o_y,          32'd0);
    check("async sel",   32'(o_sel),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("no valid after abort %0d", j), 32'(o_valid), 32'd0);
    end
    run_one(32'hFE80_0000, y);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sigm_seq.md
# sigm_seq

Sequencer for the piecewise-quadratic sigmoid. It accepts one Q8.24 operand per request, drives the 3-bit segment select of the external `sigm_coef` selector, and evaluates y = c0 + |x|·(c1 + |x|·c2) in Horner form on one internal shared multiplier. For negative inputs it applies the symmetry y = 1.0 − p. It sits between a neuron's weighted-sum output and its activation register.

## Interface
- `WIDTH`, 32: operand and coefficient width. Format is Q8.24, two's complement; 1.0 = 0x01000000.
- `FRAC`, 24: fractional bits; the product is taken as bits [FRAC+WIDTH-1:FRAC].
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  request strobe; sampled only in IDLE.
- `i_x`  in  WIDTH  operand; sampled on the accepting edge only.
- `o_sel`  out  3  segment select to `sigm_coef` `i_sel`; registered.
- `i_coef0`, `i_coef1`, `i_coef2`  in  WIDTH each  coefficients returned combinationally by `sigm_coef` for `o_sel`.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_valid`  out  1  one-cycle pulse; `o_y` is valid in that cycle.
- `o_y`  out  WIDTH  sigmoid result; held until the next result.

## Operation
- States: IDLE → H1 → H2 → FIN → IDLE. No other transitions, apart from reset.
- **IDLE**
  - On `i_start`=1: register sign s = `i_x[WIDTH-1]`.
  - Register a = |`i_x`|. If `i_x` = 0x80000000, a saturates to 0x7FFFFFFF.
  - Register `o_sel` from k = a[31:24]: k=0→0, 1→1, 2→2, 3→3, 4 or 5→4, k≥6→5.
  - Go to H1.
- **H1:** acc ← `i_coef1` + mul(a, `i_coef2`). Go to H2.
- **H2:** acc ← `i_coef0` + mul(a, acc). Go to FIN.
- **FIN:** `o_y` ← s ? (0x01000000 − acc) : acc. `o_valid` ← 1. Go to IDLE.
- **mul(p,q):** signed WIDTH×WIDTH → 2·WIDTH product, truncated to bits [55:24] with no rounding. Additions are WIDTH-bit two's complement, wrap on overflow, no saturation.
- `i_start` while busy is ignored; there is no queueing. `i_x` changes after acceptance have no effect.
- `o_sel` holds its value from acceptance until the next acceptance.

## Timing
- Reset values:
  - state = IDLE.
  - `o_sel` = 0, `o_busy` = 0, `o_valid` = 0, `o_y` = 0.
  - Internal a, s, acc = 0.
- Latency: `i_start` sampled at edge k → `o_valid`=1 for the single cycle following edge k+3.
- `o_busy`=1 for the cycles after edges k, k+1 and k+2.
- Throughput: in the `o_valid` cycle the state is already IDLE, so a new `i_start` is accepted at edge k+4. Back-to-back requests therefore give one result per 4 cycles.
- Coefficients must settle within one cycle of an `o_sel` change; `sigm_coef` is purely combinational.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - No `o_valid` is produced for the aborted request.
  - The first `i_start` after reset deassertion is accepted normally.

## Test plan
- **x = 0x00000000:** `i_start` → `o_sel`=0; `o_valid` at k+4 cycle with `o_y`=0x009F3B64; `o_busy` high for exactly 3 cycles.
- **x = 0x01000000 (1.0), then x = 0xFF000000 (−1.0), back-to-back:**
  - First result: `o_sel`=1, `o_y`=0x00EB4000.
  - Second request is accepted in the first request's `o_valid` cycle. Result: `o_y`=0x0014C000.
  - The two `o_valid` pulses are 4 cycles apart.
- **Saturation region:**
  - x = 0x08000000 (8.0) → `o_sel`=5, `o_y`=0x01000000.
  - x = 0xF8000000 → `o_y`=0x00000000.
  - x = 0x80000000 → `o_sel`=5, `o_y`=0x00000000.
- **Segment boundaries:**
  - x = 0x04000000 and x = 0x05FFFFFF → `o_sel`=4.
  - x = 0x06000000 → `o_sel`=5.
  - x = 0x00FFFFFF → `o_sel`=0.
- **Busy rejection:**
  - Hold `i_start`=1 continuously with x changing every cycle.
  - Only the x values present at edges k, k+4, k+8… are processed.
  - Each result matches the polynomial for that sampled x only.
- **Reset mid-operation:** assert `rst` asynchronously during H2 → `o_busy`, `o_valid`, `o_y`, `o_sel` go to 0 without waiting for a clock edge. No `o_valid` appears afterwards, and a fresh request yields a correct result 4 cycles later.
